// File: rtl/linescroll_sched_if.sv
// Scroll request channel between the line-scroll scheduler and the framebuffer reader.
// The scheduler (master) drives the request; the reader (slave) accepts it with ready.
interface linescroll_sched_if #(
    parameter int LGPEND = 4
);
    logic              o_scroll_valid;
    logic              i_scroll_ready;
    logic [LGPEND-1:0] o_scroll_count;

    modport master (
        output o_scroll_valid,
        output o_scroll_count,
        input  i_scroll_ready
    );

    modport slave (
        input  o_scroll_valid,
        input  o_scroll_count,
        output i_scroll_ready
    );
endinterface

// File: rtl/linescroll_sched.sv
// Counts new-line strobes and issues at most one scroll request per frame,
// advancing the circular top-row pointer of the spectrogram on each accepted request.
module linescroll_sched #(
    parameter int NROWS  = 480,
    parameter int LGROWS = 9,
    parameter int LGPEND = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_line_stb,
    input  logic              i_frame_stb,
    linescroll_sched_if.master scroll,
    output logic [LGROWS-1:0] o_top_row,
    output logic              o_overflow,
    input  logic              i_clr_overflow
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    localparam logic [LGROWS:0] NROWS_W = (LGROWS+1)'(NROWS);

    // Single conditional subtract is enough because the count never reaches NROWS.
    function automatic logic [LGROWS-1:0] wrap_row(input logic [LGROWS-1:0] row,
                                                   input logic [LGPEND-1:0] cnt);
        logic [LGROWS:0] sum;
        sum = {1'b0, row} + (LGROWS+1)'(cnt);
        if (sum >= NROWS_W)
            sum = sum - NROWS_W;
        return sum[LGROWS-1:0];
    endfunction

    logic [0:0]        r_state;
    logic [LGPEND-1:0] r_pending;
    logic [LGPEND-1:0] r_count;
    logic              r_valid;
    logic [LGROWS-1:0] r_top;
    logic              r_ovf;

    logic w_pend_max;
    logic w_take;
    logic w_hs;
    logic w_lost;

    assign w_pend_max = &r_pending;
    assign w_take     = (r_state == S_IDLE) && i_frame_stb && (r_pending != '0);
    assign w_hs       = r_valid && scroll.i_scroll_ready;
    // When a request is taken the counter restarts, so a line at saturation is not lost.
    assign w_lost     = i_line_stb && w_pend_max && !w_take;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_top     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_take)
                r_pending <= LGPEND'(i_line_stb);
            else if (i_line_stb && !w_pend_max)
                r_pending <= r_pending + 1'b1;

            if (w_lost)
                r_ovf <= 1'b1;
            else if (i_clr_overflow)
                r_ovf <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_state <= S_REQ;
                        r_valid <= 1'b1;
                        r_count <= r_pending;
                    end
                end
                S_REQ: begin
                    if (w_hs) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_top   <= wrap_row(r_top, r_count);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign scroll.o_scroll_valid = r_valid;
    assign scroll.o_scroll_count = r_count;
    assign o_top_row             = r_top;
    assign o_overflow            = r_ovf;
endmodule

// File: tb/tb_linescroll_sched.sv
// Directed bench for linescroll_sched: stimulus pushes expected scroll results,
// a negedge monitor pops and checks them at each accepted request.
module tb_linescroll_sched;
    localparam int NROWS  = 480;
    localparam int LGROWS = 9;
    localparam int LGPEND = 4;

    typedef struct {
        int count;
        int top_after;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic line_stb;
    logic frame_stb;
    logic clr_ovf;
    logic [LGROWS-1:0] top_row;
    logic ovf;

    int n_chk  = 0;
    int n_fail = 0;
    exp_t exp_q[$];

    linescroll_sched_if #(.LGPEND(LGPEND)) sif ();

    linescroll_sched #(.NROWS(NROWS), .LGROWS(LGROWS), .LGPEND(LGPEND)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_line_stb     (line_stb),
        .i_frame_stb    (frame_stb),
        .scroll         (sif),
        .o_top_row      (top_row),
        .o_overflow     (ovf),
        .i_clr_overflow (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops on every handshake, then checks the pointer one cycle later.
    logic chk_top = 1'b0;
    int   exp_top_r = 0;
    always @(negedge clk) begin
        if (chk_top) begin
            check("top_row_after_hs", 32'(top_row), 32'(exp_top_r));
            check("valid_low_after_hs", 32'(sif.o_scroll_valid), 32'd0);
            chk_top <= 1'b0;
        end
        if (sif.o_scroll_valid && sif.i_scroll_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_request", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("scroll_count", 32'(sif.o_scroll_count), 32'(e.count));
                exp_top_r <= e.top_after;
                chk_top   <= 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) begin
            line_stb = 1'b1;
            tick();
        end
        line_stb = 1'b0;
    endtask

    task automatic frame();
        frame_stb = 1'b1;
        tick();
        frame_stb = 1'b0;
    endtask

    task automatic handshake();
        sif.i_scroll_ready = 1'b1;
        tick();
        sif.i_scroll_ready = 1'b0;
        tick();
    endtask

    task automatic do_scroll(input int n, input int exp_top);
        exp_t e;
        lines(n);
        e.count = n;
        e.top_after = exp_top;
        exp_q.push_back(e);
        frame();
        check("valid_after_frame", 32'(sif.o_scroll_valid), 32'd1);
        handshake();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        line_stb = 1'b0;
        frame_stb = 1'b0;
        clr_ovf = 1'b0;
        sif.i_scroll_ready = 1'b0;

        // 1. reset
        tick();
        tick();
        check("rst_valid", 32'(sif.o_scroll_valid), 32'd0);
        check("rst_count", 32'(sif.o_scroll_count), 32'd0);
        check("rst_top", 32'(top_row), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_valid", 32'(sif.o_scroll_valid), 32'd0);

        // 2. basic request, ready two cycles later
        lines(3);
        e.count = 3; e.top_after = 3;
        exp_q.push_back(e);
        frame();
        check("basic_valid", 32'(sif.o_scroll_valid), 32'd1);
        check("basic_count", 32'(sif.o_scroll_count), 32'd3);
        tick();
        tick();
        check("basic_hold_count", 32'(sif.o_scroll_count), 32'd3);
        handshake();

        // 3. advance to 478 then wrap
        for (int k = 0; k < 31; k++)
            do_scroll(15, 3 + 15 * (k + 1));
        do_scroll(10, 478);
        check("pre_wrap_top", 32'(top_row), 32'd478);
        do_scroll(5, 3);

        // 4. overflow
        lines(17);
        check("ovf_set", 32'(ovf), 32'd1);
        e.count = 15; e.top_after = 18;
        exp_q.push_back(e);
        frame();
        check("ovf_count", 32'(sif.o_scroll_count), 32'd15);
        handshake();
        check("ovf_sticky", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);
        lines(15);
        check("ovf_not_at_15", 32'(ovf), 32'd0);
        line_stb = 1'b1;
        clr_ovf = 1'b1;
        tick();
        line_stb = 1'b0;
        clr_ovf = 1'b0;
        check("ovf_wins_over_clr", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared2", 32'(ovf), 32'd0);
        e.count = 15; e.top_after = 33;
        exp_q.push_back(e);
        frame();
        handshake();

        // 5. simultaneous line and frame; frame during REQ
        lines(2);
        e.count = 2; e.top_after = 35;
        exp_q.push_back(e);
        line_stb = 1'b1;
        frame_stb = 1'b1;
        tick();
        line_stb = 1'b0;
        frame_stb = 1'b0;
        check("simul_count", 32'(sif.o_scroll_count), 32'd2);
        frame();
        check("req_frame_ignored", 32'(sif.o_scroll_count), 32'd2);
        handshake();
        e.count = 1; e.top_after = 36;
        exp_q.push_back(e);
        frame();
        check("carry_count", 32'(sif.o_scroll_count), 32'd1);
        handshake();

        // 6. reset during REQ
        lines(4);
        frame();
        check("r6_valid", 32'(sif.o_scroll_valid), 32'd1);
        check("r6_count", 32'(sif.o_scroll_count), 32'd4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("r6_valid_drop", 32'(sif.o_scroll_valid), 32'd0);
        check("r6_top", 32'(top_row), 32'd0);
        check("r6_count_rst", 32'(sif.o_scroll_count), 32'd0);
        frame();
        tick();
        check("r6_no_request", 32'(sif.o_scroll_valid), 32'd0);
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
